// File: rtl/ex_wb_stage.sv
// EX->WB back end: executes the EX-stage control strobes, owns HI/LO, GPIO and the
// retired-instruction counter, and drives the registered register-file write port.
module ex_wb_stage #(
    parameter int DATA_W = 32,
    parameter int GPIO_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_FETCH,
    input  logic              instr_valid_EX,
    input  logic              enhilo_EX,
    input  logic [1:0]        regsel_EX,
    input  logic              regwrite_EX,
    input  logic              rdrt_EX,
    input  logic              GPIO_OUT,
    input  logic              GPIO_IN,
    input  logic [4:0]        rt_EX,
    input  logic [4:0]        rd_EX,
    input  logic [DATA_W-1:0] lo_EX,
    input  logic [DATA_W-1:0] hi_EX,
    input  logic [DATA_W-1:0] readdata1_EX,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              regwrite_WB,
    output logic [4:0]        regdest_WB,
    output logic [DATA_W-1:0] writedata_WB,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q,
    output logic [31:0]       retire_count
);

    logic              w_act;
    logic [DATA_W-1:0] w_gpio_ext;
    logic [DATA_W-1:0] w_result;
    logic [4:0]        w_dest;

    logic              r_regwrite_wb;
    logic [4:0]        r_regdest_wb;
    logic [DATA_W-1:0] r_writedata_wb;
    logic [GPIO_W-1:0] r_gpio_out;
    logic [GPIO_W-1:0] r_gpio_meta;
    logic [GPIO_W-1:0] r_gpio_sync;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [31:0]       r_retire_count;

    // Strobes are only meaningful for a real, unstalled instruction; everything below gates on this.
    assign w_act  = ~stall_FETCH & instr_valid_EX;
    assign w_dest = rdrt_EX ? rt_EX : rd_EX;

    always_comb begin
        w_gpio_ext = '0;
        w_gpio_ext[GPIO_W-1:0] = r_gpio_sync;
    end

    // mfhi/mflo read the HI/LO contents from before this edge, so a mult directly ahead is visible.
    always_comb begin
        w_result = lo_EX;
        if (GPIO_IN) begin
            w_result = w_gpio_ext;
        end else begin
            case (regsel_EX)
                2'd1:    w_result = r_hi;
                2'd2:    w_result = r_lo;
                default: w_result = lo_EX;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gpio_meta <= '0;
            r_gpio_sync <= '0;
        end else begin
            r_gpio_meta <= gpio_in;
            r_gpio_sync <= r_gpio_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_act && enhilo_EX) begin
            r_hi <= hi_EX;
            r_lo <= lo_EX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gpio_out <= '0;
        end else if (w_act && GPIO_OUT) begin
            r_gpio_out <= readdata1_EX[GPIO_W-1:0];
        end
    end

    // A bubble clears the write enable but leaves the last address/data in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite_wb  <= 1'b0;
            r_regdest_wb   <= '0;
            r_writedata_wb <= '0;
        end else begin
            r_regwrite_wb <= w_act & regwrite_EX & ~GPIO_OUT;
            if (w_act) begin
                r_regdest_wb   <= w_dest;
                r_writedata_wb <= w_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_count <= '0;
        end else if (w_act) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign regwrite_WB  = r_regwrite_wb;
    assign regdest_WB   = r_regdest_wb;
    assign writedata_WB = r_writedata_wb;
    assign gpio_out     = r_gpio_out;
    assign hi_q         = r_hi;
    assign lo_q         = r_lo;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: hand-computed vectors for ALU writes, HI/LO moves,
// GPIO read/write, stalls, counter wrap and asynchronous reset.
module tb_ex_wb_stage;

   logic        clk;
   logic        rst;
   logic        stallFetch;
   logic        instrValid;
   logic        enHiLo;
   logic [1:0]  regSel;
   logic        regWrite;
   logic        rdRt;
   logic        gpioOutStrobe;
   logic        gpioInStrobe;
   logic [4:0]  rtEx;
   logic [4:0]  rdEx;
   logic [31:0] loEx;
   logic [31:0] hiEx;
   logic [31:0] readData1;
   logic [31:0] gpioIn;

   logic        regWriteWb;
   logic [4:0]  regDestWb;
   logic [31:0] writeDataWb;
   logic [31:0] gpioOut;
   logic [31:0] hiQ;
   logic [31:0] loQ;
   logic [31:0] retireCount;

   int errorCount = 0;
   int checkCount = 0;

   ex_wb_stage #(.DATA_W(32), .GPIO_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_FETCH    (stallFetch),
      .instr_valid_EX (instrValid),
      .enhilo_EX      (enHiLo),
      .regsel_EX      (regSel),
      .regwrite_EX    (regWrite),
      .rdrt_EX        (rdRt),
      .GPIO_OUT       (gpioOutStrobe),
      .GPIO_IN        (gpioInStrobe),
      .rt_EX          (rtEx),
      .rd_EX          (rdEx),
      .lo_EX          (loEx),
      .hi_EX          (hiEx),
      .readdata1_EX   (readData1),
      .gpio_in        (gpioIn),
      .regwrite_WB    (regWriteWb),
      .regdest_WB     (regDestWb),
      .writedata_WB   (writeDataWb),
      .gpio_out       (gpioOut),
      .hi_q           (hiQ),
      .lo_q           (loQ),
      .retire_count   (retireCount)
   );

   // Free-running 10-time-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one EX-stage instruction, then lets it cross the next rising edge and settle.
   task automatic applyStimulus(
      input logic        stall,
      input logic        valid,
      input logic        hilo,
      input logic [1:0]  sel,
      input logic        wr,
      input logic        useRt,
      input logic        gOut,
      input logic        gIn,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [31:0] lo,
      input logic [31:0] hi,
      input logic [31:0] rs
   );
      stallFetch    = stall;
      instrValid    = valid;
      enHiLo        = hilo;
      regSel        = sel;
      regWrite      = wr;
      rdRt          = useRt;
      gpioOutStrobe = gOut;
      gpioInStrobe  = gIn;
      rtEx          = rt;
      rdEx          = rd;
      loEx          = lo;
      hiEx          = hi;
      readData1     = rs;
      @(posedge clk);
      #1;
   endtask

   // Checks every output of the block in one go.
   task automatic checkAll(input string tag, input logic wr, input logic [4:0] dest,
                           input logic [31:0] data, input logic [31:0] gOut,
                           input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] cnt);
      checkOutput({tag, ".regwrite"}, {31'b0, regWriteWb}, {31'b0, wr});
      checkOutput({tag, ".regdest"}, {27'b0, regDestWb}, {27'b0, dest});
      checkOutput({tag, ".writedata"}, writeDataWb, data);
      checkOutput({tag, ".gpio_out"}, gpioOut, gOut);
      checkOutput({tag, ".hi_q"}, hiQ, hi);
      checkOutput({tag, ".lo_q"}, loQ, lo);
      checkOutput({tag, ".retire"}, retireCount, cnt);
   endtask

   initial begin
      stallFetch = 1'b0; instrValid = 1'b0; enHiLo = 1'b0; regSel = 2'd0;
      regWrite = 1'b0; rdRt = 1'b0; gpioOutStrobe = 1'b0; gpioInStrobe = 1'b0;
      rtEx = '0; rdEx = '0; loEx = '0; hiEx = '0; readData1 = '0; gpioIn = '0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      checkAll("reset", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0);
      #9 rst = 1'b1;

      // ADD rd=5
      applyStimulus(0, 1, 0, 2'd0, 1, 0, 0, 0, 5'd0, 5'd5, 32'h1234, 32'h0, 32'h0);
      checkAll("add", 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 32'd1);

      // mult, then mfhi r3 and mflo r4 back to back
      applyStimulus(0, 1, 1, 2'd0, 0, 0, 0, 0, 5'd0, 5'd0, 32'hB, 32'hA, 32'h0);
      checkAll("mult", 1'b0, 5'd0, 32'hB, 32'h0, 32'hA, 32'hB, 32'd2);
      applyStimulus(0, 1, 0, 2'd1, 1, 0, 0, 0, 5'd0, 5'd3, 32'h999, 32'h0, 32'h0);
      checkAll("mfhi", 1'b1, 5'd3, 32'hA, 32'h0, 32'hA, 32'hB, 32'd3);
      applyStimulus(0, 1, 0, 2'd2, 1, 0, 0, 0, 5'd0, 5'd4, 32'h888, 32'h0, 32'h0);
      checkAll("mflo", 1'b1, 5'd4, 32'hB, 32'h0, 32'hA, 32'hB, 32'd4);

      // Reserved regsel 3 behaves as ALU result
      applyStimulus(0, 1, 0, 2'd3, 1, 0, 0, 0, 5'd0, 5'd6, 32'h77, 32'h0, 32'h0);
      checkAll("sel3", 1'b1, 5'd6, 32'h77, 32'h0, 32'hA, 32'hB, 32'd5);

      // GPIO write suppresses the register write
      applyStimulus(0, 1, 0, 2'd0, 1, 0, 1, 0, 5'd0, 5'd8, 32'h5, 32'h0, 32'hDEADBEEF);
      checkAll("gpiowr", 1'b0, 5'd8, 32'h5, 32'hDEADBEEF, 32'hA, 32'hB, 32'd6);

      // GPIO read after the input has settled through the synchronizer
      gpioIn = 32'h55;
      repeat (3) applyStimulus(0, 0, 0, 2'd0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      checkAll("idle", 1'b0, 5'd8, 32'h5, 32'hDEADBEEF, 32'hA, 32'hB, 32'd6);
      applyStimulus(0, 1, 0, 2'd1, 1, 0, 0, 1, 5'd0, 5'd7, 32'h1, 32'h0, 32'h0);
      checkAll("gpiord", 1'b1, 5'd7, 32'h55, 32'hDEADBEEF, 32'hA, 32'hB, 32'd7);

      // I-type: destination is rt
      applyStimulus(0, 1, 0, 2'd0, 1, 1, 0, 0, 5'd9, 5'd2, 32'h42, 32'h0, 32'h0);
      checkAll("itype", 1'b1, 5'd9, 32'h42, 32'hDEADBEEF, 32'hA, 32'hB, 32'd8);

      // Stalled cycles with live strobes change nothing
      repeat (3) applyStimulus(1, 1, 1, 2'd0, 1, 0, 1, 0, 5'd0, 5'd1, 32'hFF, 32'hFF, 32'h0);
      checkAll("stall", 1'b0, 5'd9, 32'h42, 32'hDEADBEEF, 32'hA, 32'hB, 32'd8);

      // Invalid instruction with X strobes
      applyStimulus(0, 0, 1'bx, 2'bxx, 1'bx, 1'bx, 1'bx, 1'bx, 5'bx, 5'bx, 32'bx, 32'bx, 32'bx);
      checkAll("invalid", 1'b0, 5'd9, 32'h42, 32'hDEADBEEF, 32'hA, 32'hB, 32'd8);

      // GPIO_OUT and GPIO_IN together: write happens, data is the read, no regfile write
      applyStimulus(0, 1, 0, 2'd0, 1, 0, 1, 1, 5'd0, 5'd10, 32'h3, 32'h0, 32'h1234);
      checkAll("gpioboth", 1'b0, 5'd10, 32'h55, 32'h1234, 32'hA, 32'hB, 32'd9);

      // Counter wrap from a preloaded value
      force dut.r_retire_count = 32'hFFFF_FFFE;
      #1 release dut.r_retire_count;
      applyStimulus(0, 1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      checkOutput("wrap.max", retireCount, 32'hFFFF_FFFF);
      applyStimulus(0, 1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      checkOutput("wrap.zero", retireCount, 32'h0);
      applyStimulus(0, 1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      checkOutput("wrap.one", retireCount, 32'h1);

      // Asynchronous reset between edges clears everything at once
      applyStimulus(0, 1, 1, 2'd0, 1, 0, 1, 0, 5'd0, 5'd12, 32'h66, 32'h67, 32'h68);
      #2 rst = 1'b0;
      #1;
      checkAll("midrst", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0);
      #1 rst = 1'b1;

      // First post-reset edge: synchronizer was cleared, so GPIO read returns 0
      applyStimulus(0, 1, 0, 2'd0, 1, 0, 0, 1, 5'd0, 5'd7, 32'h1, 32'h0, 32'h0);
      checkAll("postrst", 1'b1, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0, 32'd1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
